// File: rtl/aligned_ram_seq.sv
// aligned_ram_seq: narrow-write / wide-read RAM with auto-increment write pointer and pipelined read
module aligned_ram_seq #(
  parameter int DIN_WIDTH = 32,
  parameter int N_DIN_TO_DOUT = 4,
  parameter int DOUT_ADDR_WIDTH = 10,
  parameter int READ_LATENCY = 2,
  localparam int NB = $clog2(N_DIN_TO_DOUT),
  localparam int WA = DOUT_ADDR_WIDTH + NB,
  localparam int RW = N_DIN_TO_DOUT * DIN_WIDTH
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       wr_en,
  input  logic                       wr_auto,
  input  logic [WA-1:0]              wr_addr,
  input  logic [DIN_WIDTH-1:0]       wr_data,
  input  logic                       ptr_load,
  input  logic [WA-1:0]              ptr_load_val,
  output logic [WA-1:0]              wr_ptr,
  output logic                       wr_wrap,
  input  logic                       rd_en,
  input  logic [DOUT_ADDR_WIDTH-1:0] rd_addr,
  output logic [RW-1:0]              rd_data,
  output logic                       rd_valid
);
  logic [DIN_WIDTH-1:0] mem [2**WA];
  logic [WA-1:0] eff_addr;
  logic auto_wr;
  logic [RW-1:0] row;
  logic [RW-1:0] pipe [READ_LATENCY];
  logic [READ_LATENCY-1:0] vld;
  assign auto_wr = wr_en & wr_auto;
  assign eff_addr = wr_auto ? (ptr_load ? ptr_load_val : wr_ptr) : wr_addr;
  assign rd_data = pipe[READ_LATENCY-1];
  assign rd_valid = vld[READ_LATENCY-1];
  // gather the addressed row; slice index is concatenated below the row address
  always_comb begin
    row = '0;
    for (int i = 0; i < N_DIN_TO_DOUT; i++)
      row[i*DIN_WIDTH +: DIN_WIDTH] = mem[(WA'(rd_addr) << NB) | WA'(i)];
  end
  // single write port; contents deliberately not reset
  always_ff @(posedge clk)
    if (wr_en) mem[eff_addr] <= wr_data;
  // write pointer and wrap pulse; a load in the same cycle as an auto write wins the address
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wr_ptr <= '0;
      wr_wrap <= 1'b0;
    end else begin
      wr_ptr <= (ptr_load ? ptr_load_val : wr_ptr) + WA'(auto_wr);
      wr_wrap <= auto_wr && eff_addr == '1;
    end
  // stage 0 captures the row before this cycle's write lands (read-before-write); later stages advance only with valid data so rd_data holds
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      vld <= '0;
      for (int k = 0; k < READ_LATENCY; k++) pipe[k] <= '0;
    end else begin
      vld <= READ_LATENCY'({vld, rd_en});
      if (rd_en) pipe[0] <= row;
      for (int k = 1; k < READ_LATENCY; k++)
        if (vld[k-1]) pipe[k] <= pipe[k-1];
    end
endmodule
